// File: rtl/reg_file_sb.sv
// Register file with 2 registered read ports, 1 write port and a per-entry pending scoreboard.
// Optional same-edge write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_sb #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en_1,
    input  logic [ADDR_W-1:0] read_add_1,
    input  logic              rd_en_2,
    input  logic [ADDR_W-1:0] read_add_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] write_add,
    input  logic [DATA_W-1:0] write_inp,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_add,
    output logic [DATA_W-1:0] read_out_1,
    output logic [DATA_W-1:0] read_out_2,
    output logic              rd_vld_1,
    output logic              rd_vld_2,
    output logic              pend_1,
    output logic              pend_2,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic              cnt_inc;
    logic              cnt_dec;
    logic [DATA_W-1:0] rdata_1;
    logic [DATA_W-1:0] rdata_2;
    logic              rpend_1;
    logic              rpend_2;

    // A same-address reservation overrides the write's clear, so no decrement then.
    always_comb begin
        cnt_inc = rsv_en && !pending[rsv_add];
        cnt_dec = wr_en && pending[write_add] && !(rsv_en && (rsv_add == write_add));
    end

    always_comb begin
        rdata_1 = mem[read_add_1];
        rpend_1 = pending[read_add_1];
        rdata_2 = mem[read_add_2];
        rpend_2 = pending[read_add_2];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && (write_add == read_add_1)) begin
            rdata_1 = write_inp;
            rpend_1 = 1'b0;
        end
        if (wr_en && (write_add == read_add_2)) begin
            rdata_2 = write_inp;
            rpend_2 = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pending <= '0;
        end else begin
            if (wr_en) begin
                mem[write_add]     <= write_inp;
                pending[write_add] <= 1'b0;
            end
            if (rsv_en) begin
                pending[rsv_add] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cnt <= '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   pend_cnt <= pend_cnt + CNT_ONE;
                2'b01:   pend_cnt <= pend_cnt - CNT_ONE;
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    // Read stage: data/pending captured only on request, strobe every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_out_1 <= '0;
            read_out_2 <= '0;
            pend_1     <= 1'b0;
            pend_2     <= 1'b0;
            rd_vld_1   <= 1'b0;
            rd_vld_2   <= 1'b0;
        end else begin
            rd_vld_1 <= rd_en_1;
            rd_vld_2 <= rd_en_2;
            if (rd_en_1) begin
                read_out_1 <= rdata_1;
                pend_1     <= rpend_1;
            end
            if (rd_en_2) begin
                read_out_2 <= rdata_2;
                pend_2     <= rpend_2;
            end
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: driver updates an array model and queues expectations,
// a negedge monitor pops and compares whenever a read strobe or count update appears.
module tb_reg_file_sb;
    logic       clk = 1'b0;
    logic       rst;
    logic       rd_en_1, rd_en_2, wr_en, rsv_en;
    logic [4:0] read_add_1, read_add_2, write_add, rsv_add;
    logic [7:0] write_inp;
    logic [7:0] read_out_1, read_out_2;
    logic       rd_vld_1, rd_vld_2, pend_1, pend_2;
    logic [5:0] pend_cnt;

    typedef struct {
        logic [7:0] d;
        logic       p;
    } rd_t;

    rd_t        q1[$], q2[$];
    int         qc[$];
    rd_t        last1, last2;
    logic [7:0] m_mem [32];
    bit         m_pend [32];
    int         n_cmp = 0;
    int         n_fail = 0;

    reg_file_sb #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .rd_en_1(rd_en_1), .read_add_1(read_add_1),
        .rd_en_2(rd_en_2), .read_add_2(read_add_2),
        .wr_en(wr_en), .write_add(write_add), .write_inp(write_inp),
        .rsv_en(rsv_en), .rsv_add(rsv_add),
        .read_out_1(read_out_1), .read_out_2(read_out_2),
        .rd_vld_1(rd_vld_1), .rd_vld_2(rd_vld_2),
        .pend_1(pend_1), .pend_2(pend_2),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon_port(input int k, input logic vld, input logic [7:0] d, input logic p);
        rd_t e;
        if (vld) begin
            if ((k == 1 && q1.size() == 0) || (k == 2 && q2.size() == 0)) begin
                chk($sformatf("rd_vld_%0d_unexpected", k), 32'(vld), 32'd0);
            end else begin
                e = (k == 1) ? q1.pop_front() : q2.pop_front();
                chk($sformatf("read_out_%0d", k), 32'(d), 32'(e.d));
                chk($sformatf("pend_%0d", k), 32'(p), 32'(e.p));
                if (k == 1) last1 = e; else last2 = e;
            end
        end else begin
            e = (k == 1) ? last1 : last2;
            chk($sformatf("read_out_%0d_hold", k), 32'(d), 32'(e.d));
            chk($sformatf("pend_%0d_hold", k), 32'(p), 32'(e.p));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_port(1, rd_vld_1, read_out_1, pend_1);
            mon_port(2, rd_vld_2, read_out_2, pend_2);
            if (qc.size() != 0) chk("pend_cnt", 32'(pend_cnt), 32'(qc.pop_front()));
        end
    end

    task automatic idle();
        rd_en_1 = 0; rd_en_2 = 0; wr_en = 0; rsv_en = 0;
        read_add_1 = '0; read_add_2 = '0; write_add = '0; rsv_add = '0; write_inp = '0;
    endtask

    function automatic rd_t model_read(input logic [4:0] a);
        rd_t e;
        e.d = m_mem[a];
        e.p = m_pend[a];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && write_add == a) begin
            e.d = write_inp;
            e.p = 1'b0;
        end
`endif
        return e;
    endfunction

    // Inputs are already applied; consume one edge, update model, return at edge+1.
    task automatic step();
        int c;
        @(posedge clk);
        if (rd_en_1) q1.push_back(model_read(read_add_1));
        if (rd_en_2) q2.push_back(model_read(read_add_2));
        if (wr_en) begin
            m_mem[write_add]  = write_inp;
            m_pend[write_add] = 1'b0;
        end
        if (rsv_en) m_pend[rsv_add] = 1'b1;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
        qc.push_back(c);
        #1;
        idle();
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        q1.delete(); q2.delete(); qc.delete();
        last1 = '{8'h00, 1'b0};
        last2 = '{8'h00, 1'b0};
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_read_out_1"}, 32'(read_out_1), 32'd0);
        chk({tag, "_read_out_2"}, 32'(read_out_2), 32'd0);
        chk({tag, "_rd_vld_1"}, 32'(rd_vld_1), 32'd0);
        chk({tag, "_rd_vld_2"}, 32'(rd_vld_2), 32'd0);
        chk({tag, "_pend_1"}, 32'(pend_1), 32'd0);
        chk({tag, "_pend_2"}, 32'(pend_2), 32'd0);
        chk({tag, "_pend_cnt"}, 32'(pend_cnt), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_clear();
        #12;
        chk_zero_outputs("por");
        #1 rst = 1'b0;

        // Dual-port read of the same freshly written entry.
        wr_en = 1; write_add = 5'd11; write_inp = 8'hA5; step();
        rd_en_1 = 1; read_add_1 = 5'd11; rd_en_2 = 1; read_add_2 = 5'd11; step();
        chk("dual_rd_1", 32'(read_out_1), 32'hA5);
        chk("dual_rd_2", 32'(read_out_2), 32'hA5);
        chk("dual_vld", 32'({rd_vld_1, rd_vld_2}), 32'h3);

        // Reservations, duplicate reservation, and release by write.
        rsv_en = 1; rsv_add = 5'd3; step();
        rsv_en = 1; rsv_add = 5'd4; step();
        rsv_en = 1; rsv_add = 5'd3; step();
        chk("cnt_after_rsv", 32'(pend_cnt), 32'd2);
        wr_en = 1; write_add = 5'd3; write_inp = 8'h5A; step();
        chk("cnt_after_wr3", 32'(pend_cnt), 32'd1);
        rd_en_1 = 1; read_add_1 = 5'd3; step();
        chk("pend_3_clear", 32'(pend_1), 32'd0);

        // Reservation beats a write to the same entry.
        rsv_en = 1; rsv_add = 5'd7; wr_en = 1; write_add = 5'd7; write_inp = 8'h3C; step();
        chk("cnt_rsv_wr_same", 32'(pend_cnt), 32'd2);
        rd_en_2 = 1; read_add_2 = 5'd7; step();
        chk("rsv_wr_data", 32'(read_out_2), 32'h3C);
        chk("rsv_wr_pend", 32'(pend_2), 32'd1);

        // Read of an address being written on the same edge.
        wr_en = 1; write_add = 5'd9; write_inp = 8'h11; step();
        rd_en_1 = 1; read_add_1 = 5'd9; wr_en = 1; write_add = 5'd9; write_inp = 8'h22; step();
`ifdef REG_FILE_BYPASS_EN
        chk("rd_during_wr", 32'(read_out_1), 32'h22);
`else
        chk("rd_during_wr", 32'(read_out_1), 32'h11);
`endif

        // Fill the scoreboard, then writes to a non-pending entry must not move the count.
        for (int i = 0; i < 32; i++) begin
            rsv_en = 1; rsv_add = 5'(i); step();
        end
        chk("cnt_full", 32'(pend_cnt), 32'd32);
        wr_en = 1; write_add = 5'd0; write_inp = 8'h01; step();
        chk("cnt_wr0_pending", 32'(pend_cnt), 32'd31);
        wr_en = 1; write_add = 5'd0; write_inp = 8'h02; step();
        chk("cnt_wr0_idle", 32'(pend_cnt), 32'd31);

        // Mid-cycle reset pulse: outputs clear immediately, in-flight reads discarded.
        rd_en_1 = 1; read_add_1 = 5'd11; wr_en = 1; write_add = 5'd12; write_inp = 8'hEE; step();
        #1 rst = 1'b1;
        model_clear();
        #1 chk_zero_outputs("mid_rst");
        #1 rst = 1'b0;
        rd_en_1 = 1; read_add_1 = 5'd11; rd_en_2 = 1; read_add_2 = 5'd12; step();
        chk("post_rst_rd_11", 32'(read_out_1), 32'd0);
        chk("post_rst_rd_12", 32'(read_out_2), 32'd0);

        // Randomized traffic with a narrow address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            bit narrow;
            narrow     = ($urandom_range(0, 1) == 1);
            rd_en_1    = ($urandom_range(0, 2) != 0);
            rd_en_2    = ($urandom_range(0, 2) != 0);
            wr_en      = ($urandom_range(0, 1) == 1);
            rsv_en     = ($urandom_range(0, 2) == 0);
            read_add_1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
            read_add_2 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
            write_add  = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
            rsv_add    = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
            write_inp  = 8'($urandom);
            step();
        end

        repeat (2) @(negedge clk);
        #1;
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        chk("qc_drained", 32'(qc.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
